data_ram_ctrl: RTL and testbench



---
 rtl/data_ram_pkg.sv | 34 +++
 rtl/data_ram_ctrl_if.sv | 38 +++
 rtl/data_ram_lane_fmt.sv | 92 +++++++++
 rtl/data_ram_ctrl.sv | 150 +++++++++++++++
 tb/tb_data_ram_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_ram_pkg.sv
// ---------------------------------------------------------------------------
// data_ram_pkg
// Purpose : Shared encodings for the MEM-stage data RAM controller.
//           Access size codes, controller FSM states and a helper that maps
//           a size code to its byte count (0 for the reserved code).
// Ports   : none (package)
// ---------------------------------------------------------------------------
package data_ram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl_if
// Purpose : Request/response bus between a MEM-stage master and the data RAM.
// Signals : req_valid/req_ready/req_write/req_size/req_signed/req_addr/
//           req_wdata (request channel), resp_valid/resp_ready/resp_rdata/
//           resp_err (response channel).
//
// Handshake: on each channel a transfer happens on a rising edge where valid
// and ready are both 1. A producer holding valid keeps its payload stable and
// keeps valid high until that edge; valid never depends on ready.
// ---------------------------------------------------------------------------
interface data_ram_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram_lane_fmt.sv
// ---------------------------------------------------------------------------
// data_ram_lane_fmt
// Purpose : Combinational byte-lane formatting for the data RAM.
//           - error check (misalignment, reserved size, out of range)
//           - big-endian load assembly with sign/zero extension
//           - store split into byte lanes (lane k targets Mem[addr+k])
// Ports   : size_i, signed_i, addr_i, wdata_i  request fields
//           rbytes_i   Mem[addr+0..3], lane 0 first
//           err_o      access rejected
//           rdata_o    formatted load data (0 on error)
//           wbytes_o   store byte per lane
//           wen_o      store lane enables (0 on error)
// ---------------------------------------------------------------------------
module data_ram_lane_fmt
    import data_ram_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [3:0][7:0]   rbytes_i,
    output logic              err_o,
    output logic [31:0]       rdata_o,
    output logic [3:0][7:0]   wbytes_o,
    output logic [3:0]        wen_o
);

    logic [2:0]      nbytes;
    logic [ADDR_W:0] end_addr;
    logic            misalign;
    logic            ext;

    always_comb begin
        nbytes   = size_nbytes(size_i);
        // One extra bit so addr + nbytes cannot wrap past the top of the space.
        end_addr = {1'b0, addr_i} + (ADDR_W+1)'(nbytes);
        misalign = 1'b0;
        case (size_i)
            SZ_HALF: misalign = addr_i[0];
            SZ_WORD: misalign = |addr_i[1:0];
            default: misalign = 1'b0;
        endcase
        err_o = (size_i == SZ_RSVD) || misalign ||
                (end_addr > (ADDR_W+1)'(DEPTH));
    end

    // Lane 0 holds the most significant byte of the access.
    always_comb begin
        ext     = signed_i & rbytes_i[0][7];
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: rdata_o = {{24{ext}}, rbytes_i[0]};
            SZ_HALF: rdata_o = {{16{ext}}, rbytes_i[0], rbytes_i[1]};
            SZ_WORD: rdata_o = {rbytes_i[0], rbytes_i[1], rbytes_i[2], rbytes_i[3]};
            default: rdata_o = '0;
        endcase
        if (err_o) begin
            rdata_o = '0;
        end
    end

    always_comb begin
        wbytes_o = '0;
        wen_o    = '0;
        case (size_i)
            SZ_BYTE: begin
                wbytes_o[0] = wdata_i[7:0];
                wen_o       = 4'b0001;
            end
            SZ_HALF: begin
                wbytes_o[0] = wdata_i[15:8];
                wbytes_o[1] = wdata_i[7:0];
                wen_o       = 4'b0011;
            end
            SZ_WORD: begin
                wbytes_o[0] = wdata_i[31:24];
                wbytes_o[1] = wdata_i[23:16];
                wbytes_o[2] = wdata_i[15:8];
                wbytes_o[3] = wdata_i[7:0];
                wen_o       = 4'b1111;
            end
            default: wen_o = '0;
        endcase
        if (err_o) begin
            wen_o = '0;
        end
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// data_ram_ctrl
// Purpose : Clocked byte-addressed big-endian data RAM for the MEM stage with
//           a valid/ready request/response handshake and LATENCY-cycle reads.
//           The array is accessed on the acceptance edge; the response is
//           held in registers and presented LATENCY cycles later.
// Ports   : clk      rising-edge clock
//           rst_n    asynchronous active-low reset
//           bus      data_ram_ctrl_if slave (request and response channels)
//           state_o  current FSM state, for observation
// ---------------------------------------------------------------------------
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    data_ram_ctrl_if.slave   bus,
    output state_t           state_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Not reset; benches pre-load it hierarchically.
    logic [7:0] Mem [DEPTH];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [3:0][7:0]       rbytes, wbytes;
    logic [3:0]            wen;
    logic [3:0][IDX_W-1:0] lane_idx;
    logic [3:0]            lane_ok;
    logic [ADDR_W:0]       lane_addr;
    logic                  fmt_err;
    logic [31:0]           fmt_rdata;
    logic                  accept;

    // Lanes past the end of the array read as 0 and are never written, so a
    // non-power-of-two DEPTH cannot alias onto low addresses.
    always_comb begin
        lane_addr = '0;
        lane_idx  = '0;
        lane_ok   = '0;
        rbytes    = '0;
        for (int k = 0; k < 4; k++) begin
            lane_addr  = {1'b0, bus.req_addr} + (ADDR_W+1)'(k);
            lane_ok[k] = lane_addr < (ADDR_W+1)'(DEPTH);
            if (lane_ok[k]) begin
                lane_idx[k] = lane_addr[IDX_W-1:0];
                rbytes[k]   = Mem[lane_addr[IDX_W-1:0]];
            end
        end
    end

    data_ram_lane_fmt #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fmt (
        .size_i   (bus.req_size),
        .signed_i (bus.req_signed),
        .addr_i   (bus.req_addr),
        .wdata_i  (bus.req_wdata),
        .rbytes_i (rbytes),
        .err_o    (fmt_err),
        .rdata_o  (fmt_rdata),
        .wbytes_o (wbytes),
        .wen_o    (wen)
    );

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // Stores commit on the acceptance edge; wen is already cleared on error.
    always_ff @(posedge clk) begin
        if (accept && bus.req_write) begin
            for (int k = 0; k < 4; k++) begin
                if (wen[k]) begin
                    Mem[lane_idx[k]] <= wbytes[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rdata_d = bus.req_write ? 32'h0 : fmt_rdata;
                    err_d   = fmt_err;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                // Counter value 1 on an edge is the last waiting cycle.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_ram_ctrl
// Bench for data_ram_ctrl: one instance with LATENCY=1 and one with LATENCY=3,
// both DEPTH=256. A byte-array reference model produces expected responses.
// ---------------------------------------------------------------------------
module tb_data_ram_ctrl;
    import data_ram_pkg::*;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_ram_ctrl_if #(.ADDR_W(32)) bus1 ();
    data_ram_ctrl_if #(.ADDR_W(32)) bus3 ();
    state_t st1, st3;

    data_ram_ctrl #(.DEPTH(256), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus1),
        .state_o (st1)
    );

    data_ram_ctrl #(.DEPTH(256), .ADDR_W(32), .LATENCY(3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus3),
        .state_o (st3)
    );

    int          total = 0;
    int          bad   = 0;
    logic [32:0] exp_q[$];          // {err, rdata}
    logic [7:0]  mdl [2][256];      // reference arrays, [0]=dut1, [1]=dut3

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 1) ? 1 : 3;
    endfunction

    // Reference model: returns {err, rdata}; updates the model array on stores.
    function automatic logic [32:0] model_access(input int d, input bit wr,
            input logic [1:0] sz, input bit sgn, input logic [31:0] a,
            input logic [31:0] wd);
        int          m;
        int          n;
        logic [31:0] v;
        m = (d == 1) ? 0 : 1;
        case (sz)
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        if (n == 0) return {1'b1, 32'h0};
        if ((a % n) != 0) return {1'b1, 32'h0};
        if (({32'h0, a} + 64'(n)) > 64'd256) return {1'b1, 32'h0};
        if (wr) begin
            for (int i = 0; i < n; i++) mdl[m][a + i] = wd[8*(n-1-i) +: 8];
            return {1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mdl[m][a + i]);
        if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return {1'b0, v};
    endfunction

    // driver
    task automatic drive(input int d, input bit v, input bit wr, input logic [1:0] sz,
            input bit sgn, input logic [31:0] a, input logic [31:0] wd, input bit rr);
        if (d == 1) begin
            bus1.req_valid = v;  bus1.req_write = wr; bus1.req_size = sz;
            bus1.req_signed = sgn; bus1.req_addr = a; bus1.req_wdata = wd;
            bus1.resp_ready = rr;
        end else begin
            bus3.req_valid = v;  bus3.req_write = wr; bus3.req_size = sz;
            bus3.req_signed = sgn; bus3.req_addr = a; bus3.req_wdata = wd;
            bus3.resp_ready = rr;
        end
    endtask

    // {req_ready, resp_valid, resp_err, resp_rdata}
    function automatic logic [34:0] outs(input int d);
        if (d == 1) return {bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.resp_rdata};
        return {bus3.req_ready, bus3.resp_valid, bus3.resp_err, bus3.resp_rdata};
    endfunction

    // One full transaction. hold=0: resp_ready high with the request;
    // hold>0: resp_ready low for hold cycles after resp_valid rises.
    task automatic access(input int d, input bit wr, input logic [1:0] sz, input bit sgn,
            input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [34:0] o;
        logic [32:0] e;
        int          n;
        n = 0;
        @(negedge clk);
        o = outs(d);
        while (!o[34] && n < 50) begin
            @(negedge clk); o = outs(d); n++;
        end
        if (!o[34]) begin
            check("ready_timeout", 35'd0, 35'd1);
            return;
        end
        exp_q.push_back(model_access(d, wr, sz, sgn, a, wd));
        drive(d, 1'b1, wr, sz, sgn, a, wd, hold == 0);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, hold == 0);
        n = 1;
        o = outs(d);
        while (!o[33] && n < 20) begin
            @(negedge clk); o = outs(d); n++;
        end
        check("latency", 35'(n), 35'(lat_of(d)));
        if (exp_q.size() == 0) begin
            check("queue_empty", 35'd0, 35'd1);
            return;
        end
        e = exp_q.pop_front();
        if (!o[33]) return;
        check("resp", {2'b00, o[32:0]}, {2'b00, e});
        check("ready_in_resp", 35'(o[34]), 35'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            o = outs(d);
            check("hold_valid", 35'(o[33]), 35'd1);
            check("hold_data", {2'b00, o[32:0]}, {2'b00, e});
            check("hold_ready", 35'(o[34]), 35'd0);
        end
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        drive(d, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        o = outs(d);
        check("ready_after", 35'(o[34]), 35'd1);
        check("valid_after", 35'(o[33]), 35'd0);
    endtask

    task automatic check_mem(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check(tag, 35'(u_dut1.Mem[i]), 35'(mdl[0][i]));
            check(tag, 35'(u_dut3.Mem[i]), 35'(mdl[1][i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] init_b [8];
        int         d;
        bit         wr;
        logic [1:0] sz;
        logic [31:0] a;
        init_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(3, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = (i < 8) ? init_b[i] : 8'(i ^ 8'hA5);
            u_dut1.Mem[i] = b;
            u_dut3.Mem[i] = b;
            mdl[0][i]     = b;
            mdl[1][i]     = b;
        end

        repeat (2) @(negedge clk);
        check("rst_outs1", outs(1), {1'b1, 1'b0, 33'h0});
        check("rst_outs3", outs(3), {1'b1, 1'b0, 33'h0});
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state1", 35'(st1), 35'(ST_IDLE));
        check("rst_state3", 35'(st3), 35'(ST_IDLE));

        // LATENCY=1 directed
        access(1, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0, 0);          // 12345678
        access(1, 1'b0, SZ_BYTE, 1'b1, 32'd4, 32'h0, 0);          // FFFFFF9A
        access(1, 1'b0, SZ_BYTE, 1'b0, 32'd4, 32'h0, 0);          // 0000009A
        access(1, 1'b0, SZ_HALF, 1'b1, 32'd6, 32'h0, 0);          // FFFFDEF0
        access(1, 1'b1, SZ_HALF, 1'b0, 32'd2, 32'h0000FFD3, 0);
        access(1, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0, 0);          // 1234FFD3
        access(1, 1'b1, SZ_BYTE, 1'b0, 32'd0, 32'h000000B5, 0);
        access(1, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0, 1);          // B534FFD3
        // error cases
        access(1, 1'b0, SZ_WORD, 1'b0, 32'd2, 32'h0, 0);
        access(1, 1'b1, SZ_HALF, 1'b0, 32'd1, 32'hFFFF_FFFF, 0);
        access(1, 1'b0, SZ_BYTE, 1'b0, 32'd256, 32'h0, 0);
        access(1, 1'b1, SZ_RSVD, 1'b0, 32'd0, 32'hFFFF_FFFF, 0);
        access(1, 1'b1, SZ_WORD, 1'b0, 32'd254, 32'hFFFF_FFFF, 0);
        access(1, 1'b1, SZ_WORD, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 0);
        check_mem("err_mem", 0, 7);

        // LATENCY=3: stall, then store/load with reset during WAIT
        access(3, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'h0, 4);
        access(3, 1'b1, SZ_WORD, 1'b0, 32'd8, 32'hE35D8AC5, 0);
        @(negedge clk);
        check("pre_rst_ready", 35'(outs(3) >> 34), 35'd1);
        drive(3, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, 1'b0);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        check("wait_state", 35'(st3), 35'(ST_WAIT));
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_valid", 35'(outs(3) >> 33), 35'd2);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst", outs(3), {1'b1, 1'b0, 33'h0});
        end
        access(3, 1'b0, SZ_WORD, 1'b0, 32'd8, 32'h0, 0);          // E35D8AC5

        // random accesses on both instances
        for (int i = 0; i < 40; i++) begin
            d  = ($urandom_range(0, 1) == 1) ? 1 : 3;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15))
                                             : 32'($urandom_range(248, 263));
            access(d, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end
        check_mem("final_mem", 0, 15);
        check_mem("final_mem_top", 248, 255);
        check("queue_drained", 35'(exp_q.size()), 35'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
